booth_r4_mult: RTL and testbench

Parametrised sequential radix-4 Booth multiplier. It is the next generation of the team's radix-2 booth unit, with the same start/ready handshake and operand registering.
- Adds a per-operation signed/unsigned mode.
- Retires two multiplier bits per cycle.
- Adds a synchronous reset and a one-cycle done strobe.
- Sits beside the ALU datapath as a multi-cycle functional unit; the issuing logic polls ready.

---
 rtl/booth_r4_mult.sv | 145 ++++++++++++++
 tb/tb_booth_r4_mult.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_r4_mult.sv
// Sequential radix-4 Booth multiplier, signed or unsigned per operation, 2*nb-bit product.
// Latency: start accepted at edge T, Product valid with a one-cycle done pulse after edge T+ITER+1.
// Backpressure: start is sampled only while ready=1; requests while busy are dropped, not queued.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   start             request, sampled while ready=1
//   signed_mode       1 = two's complement operands, 0 = unsigned; sampled with start
//   A, B              multiplicand / multiplier (nb bits), sampled on the accepting edge
//   Product           2*nb-bit result, held until the next completion or reset
//   ready             idle and able to accept start
//   done              one-cycle pulse when a new Product appears
//   abort             (only with BOOTH_ABORT_EN defined) cancel the in-flight operation
//
// Optional feature macro: BOOTH_ABORT_EN
module booth_r4_mult #(
  parameter int nb = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            signed_mode,
  input  logic [nb-1:0]   A,
  input  logic [nb-1:0]   B,
`ifdef BOOTH_ABORT_EN
  input  logic            abort,
`endif
  output logic [2*nb-1:0] Product,
  output logic            ready,
  output logic            done
);

  localparam int ITER = (nb + 2) / 2;
  localparam int CW   = $clog2(ITER + 1);
  // {P_hi (nb+2), multiplier shift register (nb+2), guard}
  localparam int AW   = 2 * nb + 5;

  typedef enum logic {IDLE, CALC} state_t;

  state_t            state_q, state_d;
  logic [nb+1:0]     m_q, m_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*nb-1:0]   prod_q, prod_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;

  // The signedness of an operation is fully captured by how the operands are
  // extended here; after that a single signed datapath serves both modes.
  logic [nb+1:0]     a_ext, b_ext;
  assign a_ext = signed_mode ? {{2{A[nb-1]}}, A} : {2'b00, A};
  assign b_ext = signed_mode ? {{2{B[nb-1]}}, B} : {2'b00, B};

  // One Booth step. Arithmetic is nb+3 bits so that +/-2M never overflows.
  logic [nb+2:0]     m_ext, addend, sum;
  logic [AW-1:0]     step_acc;

  assign m_ext = {m_q[nb+1], m_q};

  always_comb begin
    addend = '0;
    unique case (acc_q[2:0])
      3'b001, 3'b010: addend = m_ext;
      3'b011:         addend = {m_ext[nb+1:0], 1'b0};
      3'b100:         addend = -{m_ext[nb+1:0], 1'b0};
      3'b101, 3'b110: addend = -m_ext;
      default:        addend = '0;
    endcase
  end

  assign sum = {acc_q[AW-1], acc_q[AW-1 -: nb+2]} + addend;
  // Arithmetic shift right by 2 of {sum, mr, guard}; the extra sum MSB falls off the top.
  assign step_acc = {sum[nb+2], sum, acc_q[nb+2:2]};

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    ready_d = ready_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (start) begin
          m_d     = a_ext;
          acc_d   = {{(nb+2){1'b0}}, b_ext, 1'b0};
          cnt_d   = CW'(ITER);
          ready_d = 1'b0;
          state_d = CALC;
        end
      end
      CALC: begin
        if (cnt_q != '0) begin
          acc_d = step_acc;
          cnt_d = cnt_q - CW'(1);
        end else begin
          // All multiplier bits retired: {P_hi, mr} now holds the full product.
          prod_d  = acc_q[2*nb:1];
          ready_d = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end
`ifdef BOOTH_ABORT_EN
        if (abort) begin
          acc_d   = acc_q;
          cnt_d   = '0;
          prod_d  = prod_q;
          ready_d = 1'b1;
          done_d  = 1'b0;
          state_d = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign Product = prod_q;
  assign ready   = ready_q;
  assign done    = done_q;

endmodule

// File: tb/tb_booth_r4_mult.sv
// Self-checking bench for booth_r4_mult at nb = 32, 12 and 4.
// Expected products are queued when an operation is issued and popped on done.
module tb_booth_r4_mult;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start32, mode32, rdy32, done32;
  logic [31:0] a32, b32;
  logic [63:0] p32;
  logic        start12, mode12, rdy12, done12;
  logic [11:0] a12, b12;
  logic [23:0] p12;
  logic        start4, mode4, rdy4, done4;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;
`ifdef BOOTH_ABORT_EN
  logic        abort32, abort12, abort4;
`endif

  int checks = 0;
  int errors = 0;
  logic [63:0] exp32_q[$];
  logic [63:0] exp12_q[$];
  logic [63:0] exp4_q[$];

  booth_r4_mult #(.nb(32)) u_dut32 (
    .clk(clk), .rst(rst), .start(start32), .signed_mode(mode32), .A(a32), .B(b32),
`ifdef BOOTH_ABORT_EN
    .abort(abort32),
`endif
    .Product(p32), .ready(rdy32), .done(done32));

  booth_r4_mult #(.nb(12)) u_dut12 (
    .clk(clk), .rst(rst), .start(start12), .signed_mode(mode12), .A(a12), .B(b12),
`ifdef BOOTH_ABORT_EN
    .abort(abort12),
`endif
    .Product(p12), .ready(rdy12), .done(done12));

  booth_r4_mult #(.nb(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .signed_mode(mode4), .A(a4), .B(b4),
`ifdef BOOTH_ABORT_EN
    .abort(abort4),
`endif
    .Product(p4), .ready(rdy4), .done(done4));

  // Reference product: operands extended to 128 bits per mode, then multiplied.
  function automatic logic [63:0] model(input int n, input logic sm,
                                        input logic [31:0] a, input logic [31:0] b);
    logic [127:0] ea, eb, msk, p;
    msk = {128{1'b1}} >> (128 - n);
    ea  = {96'b0, a} & msk;
    eb  = {96'b0, b} & msk;
    if (sm && a[n-1]) ea = ea | ~msk;
    if (sm && b[n-1]) eb = eb | ~msk;
    p   = ea * eb;
    msk = {128{1'b1}} >> (128 - 2 * n);
    p   = p & msk;
    return p[63:0];
  endfunction

  function automatic logic [63:0] prod_of(input int w);
    case (w)
      32:      return p32;
      12:      return {40'b0, p12};
      default: return {56'b0, p4};
    endcase
  endfunction

  function automatic logic done_of(input int w);
    case (w)
      32:      return done32;
      12:      return done12;
      default: return done4;
    endcase
  endfunction

  function automatic logic rdy_of(input int w);
    case (w)
      32:      return rdy32;
      12:      return rdy12;
      default: return rdy4;
    endcase
  endfunction

  task automatic push_exp(input int w, input logic [63:0] e);
    case (w)
      32:      exp32_q.push_back(e);
      12:      exp12_q.push_back(e);
      default: exp4_q.push_back(e);
    endcase
  endtask

  function automatic logic [63:0] pop_exp(input int w);
    case (w)
      32:      return exp32_q.pop_front();
      12:      return exp12_q.pop_front();
      default: return exp4_q.pop_front();
    endcase
  endfunction

  task automatic drive(input int w, input logic s, input logic sm,
                       input logic [31:0] a, input logic [31:0] b);
    case (w)
      32:      begin start32 = s; mode32 = sm; a32 = a;        b32 = b;        end
      12:      begin start12 = s; mode12 = sm; a12 = a[11:0];  b12 = b[11:0];  end
      default: begin start4  = s; mode4  = sm; a4  = a[3:0];   b4  = b[3:0];   end
    endcase
  endtask

  // Called #1 after an edge with the DUT idle; returns #1 after the accepting edge.
  task automatic start_op(input int w, input logic sm, input logic [31:0] a, input logic [31:0] b);
    drive(w, 1'b1, sm, a, b);
    @(posedge clk); #1;
    drive(w, 1'b0, sm, a, b);
  endtask

  // Counts edges until done; an expired budget is a failed comparison.
  task automatic wait_done(input int w, input int budget, output int edges);
    bit seen;
    seen  = 0;
    edges = -1;
    for (int i = 1; i <= budget && !seen; i++) begin
      @(posedge clk); #1;
      if (done_of(w)) begin
        seen  = 1;
        edges = i;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL wait_done nb=%0d: no done within %0d edges", w, budget);
    end
  endtask

  task automatic test_reset();
    int lat, pulses;
    logic [63:0] exp;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (p32 !== 64'd0 || rdy32 !== 1'b1 || done32 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state32: Product=%h ready=%b done=%b, want 0/1/0", p32, rdy32, done32);
    end
    checks++;
    if (p12 !== 24'd0 || rdy12 !== 1'b1 || p4 !== 8'd0 || rdy4 !== 1'b1 || done12 !== 1'b0 || done4 !== 1'b0) begin
      errors++;
      $display("FAIL reset_state_small: p12=%h rdy12=%b p4=%h rdy4=%b, want 0/1/0/1", p12, rdy12, p4, rdy4);
    end
    rst = 1'b0;
    @(posedge clk); #1;

    start_op(32, 1'b1, 32'd6, 32'd7);
    push_exp(32, 64'd42);
    wait_done(32, 40, lat);
    exp = pop_exp(32);
    checks++;
    if (p32 !== exp) begin
      errors++;
      $display("FAIL pre_reset_op: Product=%h want %h", p32, exp);
    end

    // Reset two cycles in the middle of an operation.
    @(posedge clk); #1;
    start_op(32, 1'b0, 32'd1000, 32'd1000);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (p32 !== 64'd0 || rdy32 !== 1'b1 || done32 !== 1'b0) begin
      errors++;
      $display("FAIL mid_calc_reset: Product=%h ready=%b done=%b, want 0/1/0", p32, rdy32, done32);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    pulses = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done32 === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0 || rdy32 !== 1'b1 || p32 !== 64'd0) begin
      errors++;
      $display("FAIL reset_no_done: done pulses=%0d ready=%b Product=%h, want 0/1/0", pulses, rdy32, p32);
    end
  endtask

  task automatic test_signed_latency();
    int lat;
    bit early;
    logic [63:0] exp;
    lat   = -1;
    early = 0;
    start_op(32, 1'b1, -32'sd7, 32'd3);
    push_exp(32, 64'hFFFFFFFF_FFFFFFEB);
    for (int i = 1; i <= 40 && lat < 0; i++) begin
      @(posedge clk); #1;
      if (done32) lat = i;
      else if (rdy32) early = 1;
    end
    checks++;
    if (lat != 18 || early) begin
      errors++;
      $display("FAIL signed_latency: done after %0d edges (ready early=%0b), want 18", lat, early);
    end
    checks++;
    if (rdy32 !== 1'b1) begin
      errors++;
      $display("FAIL signed_ready_at_done: ready=%b want 1", rdy32);
    end
    exp = pop_exp(32);
    checks++;
    if (p32 !== exp) begin
      errors++;
      $display("FAIL signed_m7x3: Product=%h want %h", p32, exp);
    end
    @(posedge clk); #1;
    checks++;
    if (done32 !== 1'b0 || p32 !== exp) begin
      errors++;
      $display("FAIL done_one_cycle: done=%b Product=%h, want 0/%h", done32, p32, exp);
    end
  endtask

  task automatic test_width_extremes();
    int lat;
    logic [63:0] exp;
    start_op(32, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    push_exp(32, 64'hFFFFFFFE_00000001);
    wait_done(32, 40, lat);
    exp = pop_exp(32);
    checks++;
    if (p32 !== exp) begin errors++; $display("FAIL unsigned_max: Product=%h want %h", p32, exp); end

    start_op(32, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
    push_exp(32, 64'h00000000_00000001);
    wait_done(32, 40, lat);
    exp = pop_exp(32);
    checks++;
    if (p32 !== exp) begin errors++; $display("FAIL signed_m1xm1: Product=%h want %h", p32, exp); end

    start_op(32, 1'b1, 32'h80000000, 32'h80000000);
    push_exp(32, 64'h40000000_00000000);
    wait_done(32, 40, lat);
    exp = pop_exp(32);
    checks++;
    if (p32 !== exp) begin errors++; $display("FAIL signed_min_sq32: Product=%h want %h", p32, exp); end

    start_op(4, 1'b1, 32'h8, 32'h8);
    push_exp(4, 64'h40);
    wait_done(4, 20, lat);
    exp = pop_exp(4);
    checks++;
    if (p4 !== exp[7:0] || lat != 4) begin
      errors++;
      $display("FAIL signed_min_sq4: Product=%h lat=%0d, want %h lat=4", p4, lat, exp[7:0]);
    end

    start_op(4, 1'b0, 32'hF, 32'hF);
    push_exp(4, 64'hE1);
    wait_done(4, 20, lat);
    exp = pop_exp(4);
    checks++;
    if (p4 !== exp[7:0]) begin errors++; $display("FAIL unsigned_max4: Product=%h want %h", p4, exp[7:0]); end

    start_op(12, 1'b1, 32'h800, 32'h800);
    push_exp(12, 64'h400000);
    wait_done(12, 20, lat);
    exp = pop_exp(12);
    checks++;
    if (p12 !== exp[23:0] || lat != 8) begin
      errors++;
      $display("FAIL signed_min_sq12: Product=%h lat=%0d, want %h lat=8", p12, lat, exp[23:0]);
    end
  endtask

  task automatic test_ignore_start();
    int lat, pulses;
    logic [63:0] exp;
    start_op(32, 1'b0, 32'd1000, 32'd3000);
    push_exp(32, 64'd3000000);
    repeat (4) @(posedge clk);
    #1;
    drive(32, 1'b1, 1'b1, 32'd5, 32'd5);
    @(posedge clk); #1;
    checks++;
    if (rdy32 !== 1'b0) begin errors++; $display("FAIL busy_ready: ready=%b want 0", rdy32); end
    drive(32, 1'b0, 1'b1, 32'd5, 32'd5);
    wait_done(32, 40, lat);
    exp = pop_exp(32);
    checks++;
    if (p32 !== exp || lat != 13) begin
      errors++;
      $display("FAIL ignore_start: Product=%h lat=%0d, want %h lat=13", p32, lat, exp);
    end
    pulses = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done32 === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0 || p32 !== exp) begin
      errors++;
      $display("FAIL ignore_no_second: done pulses=%0d Product=%h, want 0/%h", pulses, p32, exp);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [63:0] exp;
    drive(32, 1'b1, 1'b1, -32'sd2, 32'd9);
    push_exp(32, 64'hFFFFFFFF_FFFFFFEE);
    @(posedge clk); #1;
    drive(32, 1'b1, 1'b0, 32'h12345678, 32'h10);
    push_exp(32, 64'h00000001_23456780);
    wait_done(32, 40, lat);
    exp = pop_exp(32);
    checks++;
    if (p32 !== exp || lat != 18) begin
      errors++;
      $display("FAIL b2b_first: Product=%h lat=%0d, want %h lat=18", p32, lat, exp);
    end
    @(posedge clk); #1;
    checks++;
    if (rdy32 !== 1'b0 || done32 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: ready=%b done=%b, want 0/0", rdy32, done32);
    end
    drive(32, 1'b0, 1'b0, 32'd0, 32'd0);
    wait_done(32, 40, lat);
    exp = pop_exp(32);
    checks++;
    if (p32 !== exp || lat != 18) begin
      errors++;
      $display("FAIL b2b_second: Product=%h lat=%0d, want %h lat=18", p32, lat, exp);
    end
  endtask

  task automatic test_random();
    int w, lat;
    logic sm;
    logic [31:0] a, b;
    logic [63:0] exp;
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 2))
        0:       w = 4;
        1:       w = 12;
        default: w = 32;
      endcase
      a  = $urandom;
      b  = $urandom;
      sm = 1'($urandom_range(0, 1));
      if (i % 10 == 0) a = 32'h1 << (w - 1);
      if (i % 15 == 0) b = 32'hFFFFFFFF;
      start_op(w, sm, a, b);
      push_exp(w, model(w, sm, a, b));
      wait_done(w, 40, lat);
      exp = pop_exp(w);
      checks++;
      if (prod_of(w) !== exp || lat != (w + 2) / 2 + 1 || rdy_of(w) !== 1'b1) begin
        errors++;
        $display("FAIL random[%0d] nb=%0d sm=%b A=%h B=%h: Product=%h lat=%0d, want %h lat=%0d",
                 i, w, sm, a, b, prod_of(w), lat, exp, (w + 2) / 2 + 1);
      end
    end
  endtask

`ifdef BOOTH_ABORT_EN
  task automatic test_abort();
    int lat, pulses;
    logic [63:0] exp;
    start_op(32, 1'b0, 32'd11, 32'd13);
    push_exp(32, 64'd143);
    wait_done(32, 40, lat);
    exp = pop_exp(32);
    checks++;
    if (p32 !== exp) begin errors++; $display("FAIL abort_setup: Product=%h want %h", p32, exp); end
    start_op(32, 1'b0, 32'd100, 32'd100);
    repeat (2) @(posedge clk);
    #1;
    abort32 = 1'b1;
    @(posedge clk); #1;
    abort32 = 1'b0;
    checks++;
    if (rdy32 !== 1'b1 || done32 !== 1'b0 || p32 !== 64'd143) begin
      errors++;
      $display("FAIL abort_state: ready=%b done=%b Product=%h, want 1/0/8f", rdy32, done32, p32);
    end
    pulses = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done32 === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0 || p32 !== 64'd143) begin
      errors++;
      $display("FAIL abort_no_done: done pulses=%0d Product=%h, want 0/8f", pulses, p32);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    drive(32, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(12, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(4,  1'b0, 1'b0, 32'd0, 32'd0);
`ifdef BOOTH_ABORT_EN
    abort32 = 1'b0;
    abort12 = 1'b0;
    abort4  = 1'b0;
`endif
    test_reset();
    test_signed_latency();
    test_width_extremes();
    test_ignore_start();
    test_back_to_back();
    test_random();
`ifdef BOOTH_ABORT_EN
    test_abort();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
